regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised integer register file for the pipelined core; successor to the fixed 32x32, two-read-port file.
- Generalised in width, depth and read-port count.
- Adds a per-register pending-write scoreboard (busy bits set at issue, cleared at writeback, bulk-cleared on flush) so decode can detect RAW hazards directly.
- Sits between decode (reads, issue marking) and writeback (register write).

Parameters:
- XLEN, 32, data width of each register in bits.
- NREGS, 32, number of architectural registers (power of two, >= 2).
- AW, $clog2(NREGS), register address width (derived; do not override).
- NRD, 2, number of independent read ports (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses, port k at bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN].
- rd_busy  out  NRD  1 = register addressed by port k has a pending write.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- iss_en  in  1  instruction with destination issued this cycle.
- iss_addr  in  AW  destination being marked pending.
- flush  in  1  pipeline flush; clears all busy bits.
- busy_cnt  out  AW+1  number of registers currently pending.

Behaviour:
- Storage: NREGS x XLEN array plus NREGS-bit busy vector; all state updates on posedge clk.
- Reset: rst high asynchronously clears every register and every busy bit; takes precedence over all inputs, including mid-operation.
  - While in reset: rd_data = 0 on all ports, rd_busy = 0, busy_cnt = 0.
  - First write is accepted on the first rising edge after rst deasserts.
- Register 0:
  - Reads always return 0; rd_busy for addr 0 is always 0.
  - Writes to addr 0 are discarded; issue to addr 0 never sets busy.
- Read: combinational, zero latency; rd_data[k] = reg[rd_addr[k]] as stored before the current edge.
  - Same-cycle write is not visible without the optional feature.
  - rd_busy[k] = busy[rd_addr[k]] (registered value).
  - Any number of ports may read the same address.
- Write: wr_en=1 and wr_addr!=0 -> reg[wr_addr] <= wr_data at the edge.
- Busy update, per address a, at each edge, in priority order:
  1. flush=1 -> all busy bits cleared; iss_en in the same cycle is ignored.
  2. iss_en=1 and iss_addr==a (a!=0) -> busy[a] <= 1. Wins over a simultaneous writeback to a, because the newer producer is still outstanding.
  3. wr_en=1 and wr_addr==a -> busy[a] <= 0.
  4. Otherwise busy[a] holds.
- Writeback to a non-busy register: data written, busy stays 0; not an error.
- Issue to an already-busy register: stays 1; no count of multiple producers.
- busy_cnt: registered population count of the busy vector; updates one cycle after the busy change. Range 0..NREGS-1 (x0 never counted).
- Flush does not alter register contents; writebacks in the flush cycle still commit.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding: if wr_en=1, wr_addr!=0 and rd_addr[k]==wr_addr, then rd_data[k]=wr_data in the same cycle.
  - rd_busy[k] is forced to 0 for that port in that cycle, unless iss_en=1 with iss_addr==wr_addr in the same cycle, in which case it reads 1.
  - Adds one comparator and one mux per read port; no extra latency.
- Undefined: reads return the stored value only; rd_busy reflects the registered busy bit only.

Test Plan:
- Reset/zero: assert rst mid-run after writing reg5=0xDEADBEEF; then wr_en to addr 0 with 0x12345678 -> rd_data for addr 0 and addr 5 read 0, rd_busy=0, busy_cnt=0 immediately and after release.
- Basic write/read: write reg3=0x0000000A, reg7=0xFFFFFFF6; next cycle read port0=3, port1=7 -> 0x0000000A, 0xFFFFFFF6; both ports on addr 7 -> both 0xFFFFFFF6.
- Scoreboard: issue to 9, next cycle -> rd_busy=1 for addr 9, busy_cnt=1 one cycle later; writeback to 9 -> rd_busy=0 next cycle, busy_cnt=0.
- Simultaneous issue and writeback to 12 in one cycle (12 busy) -> busy[12] stays 1, data updated.
- Flush: set busy on 1, 2, 31, then flush with iss_en to addr 4 -> all rd_busy=0, busy_cnt=0; reg4 not busy; register contents unchanged.
- Bypass: same-cycle write reg6=0x55 and read addr 6 -> 0x55 with REGFILE_BYPASS_EN, old value without; with iss to 6 in the same cycle, rd_busy=1.

Source files
------------

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - read/writeback/issue bus of the scoreboarded register file
// master = decode/writeback side, slave = regfile_sb.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
);
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;
  logic [AW:0]         busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with pending-write scoreboard
// Optional write-through forwarding on read ports: define REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int NRD   = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      busy_pop;
  logic [AW:0]      busy_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wr_en && bus.wr_addr != '0) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Issue is applied after writeback so a newer producer keeps the register pending.
  always_comb begin
    busy_next = busy;
    if (bus.flush) begin
      busy_next = '0;
    end else begin
      if (bus.wr_en)  busy_next[bus.wr_addr]  = 1'b0;
      if (bus.iss_en) busy_next[bus.iss_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_comb begin
    busy_pop = '0;
    for (int i = 0; i < NREGS; i++) busy_pop = busy_pop + {{AW{1'b0}}, busy[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy       <= busy_next;
      busy_cnt_q <= busy_pop;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = bus.rd_addr[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    logic fwd;
    assign fwd = !rst && bus.wr_en && bus.wr_addr != '0 && addr == bus.wr_addr;
    assign bus.rd_data[k*XLEN +: XLEN] = fwd ? bus.wr_data : regs[addr];
    assign bus.rd_busy[k] = fwd ? (bus.iss_en && bus.iss_addr == bus.wr_addr) : busy[addr];
`else
    assign bus.rd_data[k*XLEN +: XLEN] = regs[addr];
    assign bus.rd_busy[k] = busy[addr];
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - table vectors, reset/bypass sequences and random run vs. a reference model
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();
  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit we; logic [4:0] wa; logic [31:0] wd;
    bit ie; logic [4:0] ia; bit fl;
    logic [4:0] r0; logic [4:0] r1;
    logic [31:0] d0; logic [31:0] d1;
    bit b0; bit b1; logic [5:0] cnt;
  } vec_t;

  vec_t tbl [18];

  // reference model
  logic [31:0] m_reg [NREGS];
  bit          m_busy [NREGS];
  int          m_cnt;

  function automatic vec_t mk(bit we, logic [4:0] wa, logic [31:0] wd, bit ie, logic [4:0] ia, bit fl,
                              logic [4:0] r0, logic [4:0] r1, logic [31:0] d0, logic [31:0] d1,
                              bit b0, bit b1, logic [5:0] cnt);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia; v.fl = fl;
    v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit ie, input logic [4:0] ia, input bit fl,
                       input logic [4:0] r0, input logic [4:0] r1);
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    bus.iss_en = ie; bus.iss_addr = ia; bus.flush = fl;
    bus.rd_addr = {r1, r0};
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
    m_cnt = 0;
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
`endif
    return m_reg[a];
  endfunction

  function automatic bit m_rb(input logic [4:0] a);
    if (a == 0) return 0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && bus.wr_addr == a) return bus.iss_en && bus.iss_addr == a;
`endif
    return m_busy[a];
  endfunction

  // Counter samples the pending set as it stood before the edge.
  task automatic model_edge();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
    m_cnt = c;
    if (bus.wr_en && bus.wr_addr != 0) m_reg[bus.wr_addr] = bus.wr_data;
    if (bus.flush) begin
      for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
    end else begin
      if (bus.wr_en) m_busy[bus.wr_addr] = 0;
      if (bus.iss_en && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1;
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                         input bit b0, input bit b1, input logic [5:0] cnt);
    chk({tag, ".rd0"}, bus.rd_data[31:0], d0);
    chk({tag, ".rd1"}, bus.rd_data[63:32], d1);
    chk({tag, ".busy0"}, 32'(bus.rd_busy[0]), 32'(b0));
    chk({tag, ".busy1"}, 32'(bus.rd_busy[1]), 32'(b1));
    chk({tag, ".cnt"}, 32'(bus.busy_cnt), 32'(cnt));
  endtask

  initial begin
    //            we wa  wd            ie ia  fl r0  r1  d0            d1            b0 b1 cnt
    tbl[0]  = mk(1, 3,  32'h0000000A, 0, 0,  0, 3,  7,  32'h0,        32'h0,        0, 0, 0);
    tbl[1]  = mk(1, 7,  32'hFFFFFFF6, 0, 0,  0, 3,  0,  32'h0000000A, 32'h0,        0, 0, 0);
    tbl[2]  = mk(0, 0,  0,            0, 0,  0, 3,  7,  32'h0000000A, 32'hFFFFFFF6, 0, 0, 0);
    tbl[3]  = mk(0, 0,  0,            1, 9,  0, 7,  7,  32'hFFFFFFF6, 32'hFFFFFFF6, 0, 0, 0);
    tbl[4]  = mk(0, 0,  0,            0, 0,  0, 9,  0,  32'h0,        32'h0,        1, 0, 0);
    tbl[5]  = mk(1, 9,  32'h00000099, 0, 0,  0, 3,  0,  32'h0000000A, 32'h0,        0, 0, 1);
    tbl[6]  = mk(0, 0,  0,            1, 12, 0, 9,  9,  32'h00000099, 32'h00000099, 0, 0, 1);
    tbl[7]  = mk(1, 12, 32'h0000000C, 1, 12, 0, 9,  0,  32'h00000099, 32'h0,        0, 0, 0);
    tbl[8]  = mk(0, 0,  0,            1, 1,  0, 12, 12, 32'h0000000C, 32'h0000000C, 1, 1, 1);
    tbl[9]  = mk(0, 0,  0,            1, 2,  0, 0,  0,  32'h0,        32'h0,        0, 0, 1);
    tbl[10] = mk(0, 0,  0,            1, 31, 0, 1,  0,  32'h0,        32'h0,        1, 0, 2);
    tbl[11] = mk(0, 0,  0,            0, 0,  0, 2,  1,  32'h0,        32'h0,        1, 1, 3);
    tbl[12] = mk(0, 0,  0,            1, 4,  1, 31, 12, 32'h0,        32'h0000000C, 1, 1, 4);
    tbl[13] = mk(0, 0,  0,            0, 0,  0, 4,  31, 32'h0,        32'h0,        0, 0, 4);
    tbl[14] = mk(1, 0,  32'h12345678, 0, 0,  0, 1,  2,  32'h0,        32'h0,        0, 0, 0);
    tbl[15] = mk(0, 0,  0,            1, 0,  0, 12, 3,  32'h0000000C, 32'h0000000A, 0, 0, 0);
    tbl[16] = mk(0, 0,  0,            0, 0,  0, 0,  0,  32'h0,        32'h0,        0, 0, 0);
    tbl[17] = mk(0, 0,  0,            0, 0,  0, 9,  7,  32'h00000099, 32'hFFFFFFF6, 0, 0, 0);

    idle();
    repeat (2) @(negedge clk);
    #1 chk_all("rst_state", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // table vectors: checks sample the pre-edge state of each cycle
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ie, tbl[i].ia, tbl[i].fl, tbl[i].r0, tbl[i].r1);
      #1 chk_all($sformatf("tbl%0d", i), tbl[i].d0, tbl[i].d1, tbl[i].b0, tbl[i].b1, tbl[i].cnt);
    end

    // bypass: write reg6 while reading it and re-issuing it
    @(negedge clk);
    drive(1, 6, 32'h55, 1, 6, 0, 6, 0);
`ifdef REGFILE_BYPASS_EN
    #1 chk_all("bypass", 32'h55, 0, 1, 0, 0);
`else
    #1 chk_all("bypass", 32'h0, 0, 0, 0, 0);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 6, 0);
    #1 chk_all("bypass_after", 32'h55, 0, 1, 0, 0);

    // mid-run reset with pending state
    @(negedge clk);
    drive(1, 5, 32'hDEADBEEF, 1, 8, 0, 5, 8);
    @(negedge clk);
    idle();
    bus.rd_addr = {5'd8, 5'd5};
    #1 chk_all("pre_rst", 32'hDEADBEEF, 0, 0, 1, 1);
    #2 rst = 1'b1;
    #1 chk_all("rst_async", 0, 0, 0, 0, 0);
    drive(1, 0, 32'h12345678, 1, 5, 0, 0, 5);
    repeat (2) @(negedge clk);
    #1 chk_all("rst_hold", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 5, 32'h00000077, 0, 0, 0, 0, 5);
    #1 chk_all("rst_release", 0, 0, 0, 0, 0);
    @(negedge clk);
    idle();
    bus.rd_addr = {5'd5, 5'd0};
    #1 chk_all("first_write", 0, 32'h77, 0, 0, 0);

    // random run vs. model
    @(negedge clk);
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [4:0] r0, r1;
      @(negedge clk);
      r0 = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      r1 = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7)),
            $urandom_range(0, 15) == 0, r0, r1);
      #1;
      chk("rnd.rd0", bus.rd_data[31:0], m_rd(r0));
      chk("rnd.rd1", bus.rd_data[63:32], m_rd(r1));
      chk("rnd.busy0", 32'(bus.rd_busy[0]), 32'(m_rb(r0)));
      chk("rnd.busy1", 32'(bus.rd_busy[1]), 32'(m_rb(r1)));
      chk("rnd.cnt", 32'(bus.busy_cnt), 32'(m_cnt));
      @(posedge clk);
      model_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
